// File: rtl/hop_cnt_stamper.sv
// Output-port hop-count stamper: increments (saturating) the hop field of head flits,
// checks packet framing, and buffers flits in a 2-entry skid buffer.
// Optional statistics counters are enabled with `define HOP_CNT_STAMPER_STATS_EN.
module hop_cnt_stamper #(
    parameter int FLIT_W    = 16,
    parameter int FLIT_ID_W = 2,
    parameter int HOP_CNT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [FLIT_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              hop_sat_o,
    output logic              proto_err_o,
    output logic              in_pkt_o
`ifdef HOP_CNT_STAMPER_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       sat_cnt_o
`endif
);

    localparam int TYPE_MSB = FLIT_W - 1;
    localparam int HOP_MSB  = FLIT_W - FLIT_ID_W - 1;

    localparam logic [FLIT_ID_W-1:0] TYPE_TAIL      = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] TYPE_HEAD      = FLIT_ID_W'(2);
    localparam logic [FLIT_ID_W-1:0] TYPE_HEAD_TAIL = FLIT_ID_W'(3);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t              state;
    logic [FLIT_W-1:0]   main_data;
    logic                main_vld;
    logic [FLIT_W-1:0]   skid_data;
    logic                skid_vld;

    logic [FLIT_ID_W-1:0] flit_type;
    logic [HOP_CNT_W-1:0] hop;
    logic                 is_head;
    logic                 is_tail;
    logic                 hop_max;
    logic                 drop;
    logic                 frame_err;
    logic                 accept;
    logic                 fwd;
    logic                 xfer;
    logic [FLIT_W-1:0]    stamped;

    // Handshake: a flit moves on a side only in a cycle where both its valid and ready
    // are high; valid_o/data_o stay stable until taken, and ready_o depends only on
    // the skid register so there is no combinational path from ready_i.
    assign ready_o  = ~skid_vld;
    assign valid_o  = main_vld;
    assign data_o   = main_data;
    assign in_pkt_o = (state == PKT);

    assign accept = valid_i & ready_o;
    assign fwd    = accept & ~drop;
    assign xfer   = main_vld & ready_i;

    always_comb begin
        flit_type = data_i[TYPE_MSB -: FLIT_ID_W];
        hop       = data_i[HOP_MSB -: HOP_CNT_W];
        is_head   = (flit_type == TYPE_HEAD) || (flit_type == TYPE_HEAD_TAIL);
        is_tail   = (flit_type == TYPE_TAIL) || (flit_type == TYPE_HEAD_TAIL);
        hop_max   = &hop;
        drop      = (state == IDLE) && !is_head;
        frame_err = drop || ((state == PKT) && is_head);
        stamped   = data_i;
        if (is_head && !hop_max) begin
            stamped[HOP_MSB -: HOP_CNT_W] = hop + HOP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            main_data   <= '0;
            main_vld    <= 1'b0;
            skid_data   <= '0;
            skid_vld    <= 1'b0;
            hop_sat_o   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            hop_sat_o   <= accept & is_head & hop_max;
            proto_err_o <= accept & frame_err;

            if (fwd) begin
                state <= is_tail ? IDLE : PKT;
            end

            // Skid only fills while main is stalled; accept is blocked while skid is full.
            if (xfer) begin
                if (skid_vld) begin
                    main_data <= skid_data;
                    skid_vld  <= 1'b0;
                end else if (fwd) begin
                    main_data <= stamped;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (fwd) begin
                if (!main_vld) begin
                    main_data <= stamped;
                    main_vld  <= 1'b1;
                end else begin
                    skid_data <= stamped;
                    skid_vld  <= 1'b1;
                end
            end
        end
    end

`ifdef HOP_CNT_STAMPER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_o <= '0;
            sat_cnt_o <= '0;
        end else begin
            if (accept && is_head) begin
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            end
            if (accept && is_head && hop_max && (sat_cnt_o != 16'hFFFF)) begin
                sat_cnt_o <= sat_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hop_cnt_stamper.sv
// Bench for hop_cnt_stamper: directed test-plan cases plus random traffic, checked
// against a cycle-level reference model and an expected-flit queue.
module tb_hop_cnt_stamper;

    localparam int CLK_HALF = 5;
    localparam int ACC_LIMIT = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        hop_sat_o;
    logic        proto_err_o;
    logic        in_pkt_o;
`ifdef HOP_CNT_STAMPER_STATS_EN
    logic [15:0] pkt_cnt_o;
    logic [15:0] sat_cnt_o;
`endif

    hop_cnt_stamper #(
        .FLIT_W(16),
        .FLIT_ID_W(2),
        .HOP_CNT_W(3)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .hop_sat_o(hop_sat_o),
        .proto_err_o(proto_err_o),
        .in_pkt_o(in_pkt_o)
`ifdef HOP_CNT_STAMPER_STATS_EN
        ,
        .pkt_cnt_o(pkt_cnt_o),
        .sat_cnt_o(sat_cnt_o)
`endif
    );

    // clock / reset
    always #CLK_HALF clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model + scoreboard
    logic [15:0] exp_q[$];
    logic        m_in_pkt = 1'b0;
    logic        exp_sat = 1'b0;
    logic        exp_err = 1'b0;
    logic        acc_flag = 1'b0;
    logic [15:0] m_pkt_cnt = '0;
    logic [15:0] m_sat_cnt = '0;

    function automatic logic [15:0] stamp(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15] && d[13:11] != 3'd7) r[13:11] = d[13:11] + 3'd1;
        return r;
    endfunction

    // Outputs are sampled on the falling edge; the model then predicts the next rising edge.
    always @(negedge clk_i) begin
        logic acc;
        logic head;
        logic tail;
        check("valid_o", 16'(valid_o), 16'(exp_q.size() != 0));
        check("ready_o", 16'(ready_o), 16'(exp_q.size() < 2));
        check("in_pkt_o", 16'(in_pkt_o), 16'(m_in_pkt));
        check("hop_sat_o", 16'(hop_sat_o), 16'(exp_sat));
        check("proto_err_o", 16'(proto_err_o), 16'(exp_err));
`ifdef HOP_CNT_STAMPER_STATS_EN
        check("pkt_cnt_o", pkt_cnt_o, m_pkt_cnt);
        check("sat_cnt_o", sat_cnt_o, m_sat_cnt);
`endif
        if (valid_o && exp_q.size() > 0) check("data_o", data_o, exp_q[0]);

        acc_flag = 1'b0;
        exp_sat  = 1'b0;
        exp_err  = 1'b0;
        if (rst_i) begin
            exp_q.delete();
            m_in_pkt  = 1'b0;
            m_pkt_cnt = '0;
            m_sat_cnt = '0;
        end else begin
            acc = valid_i && (exp_q.size() < 2);
            if (exp_q.size() > 0 && ready_i) void'(exp_q.pop_front());
            if (acc) begin
                head = data_i[15];
                tail = data_i[14];
                if (!m_in_pkt && !head) begin
                    exp_err = 1'b1;
                end else begin
                    exp_q.push_back(stamp(data_i));
                    exp_err  = m_in_pkt && head;
                    m_in_pkt = !tail;
                end
                if (head) begin
                    m_pkt_cnt = m_pkt_cnt + 16'd1;
                    if (data_i[13:11] == 3'd7) begin
                        exp_sat = 1'b1;
                        if (m_sat_cnt != 16'hFFFF) m_sat_cnt = m_sat_cnt + 16'd1;
                    end
                end
            end
            acc_flag = acc;
        end
    end

    // driver: called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        data_i  = d;
        valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            #1;
            n++;
        end while (!acc_flag && n < ACC_LIMIT);
        check("send_accepted", 16'(n < ACC_LIMIT), 16'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] t;
        logic [2:0] h;

        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_valid_o", 16'(valid_o), 16'd0);
        check("rst_ready_o", 16'(ready_o), 16'd1);
        check("rst_data_o", data_o, 16'h0000);
        check("rst_hop_sat_o", 16'(hop_sat_o), 16'd0);
        check("rst_proto_err_o", 16'(proto_err_o), 16'd0);
        check("rst_in_pkt_o", 16'(in_pkt_o), 16'd0);

        // single-flit packet
        ready_i = 1'b1;
        send(16'hCA55);
        check("ht_data", data_o, 16'hD255);
        check("ht_valid", 16'(valid_o), 16'd1);
        check("ht_in_pkt", 16'(in_pkt_o), 16'd0);
        check("ht_err", 16'(proto_err_o), 16'd0);

        // head/body/tail back to back
        send(16'h8A55);
        check("hbt_head", data_o, 16'h9255);
        check("hbt_in_pkt_head", 16'(in_pkt_o), 16'd1);
        send(16'h0123);
        check("hbt_body", data_o, 16'h0123);
        send(16'h4777);
        check("hbt_tail", data_o, 16'h4777);
        check("hbt_in_pkt_tail", 16'(in_pkt_o), 16'd0);

        // saturated hop count
        send(16'hB855);
        check("sat_data", data_o, 16'hB855);
        check("sat_pulse", 16'(hop_sat_o), 16'd1);
`ifdef HOP_CNT_STAMPER_STATS_EN
        check("sat_cnt_val", sat_cnt_o, 16'd1);
        check("pkt_cnt_val", pkt_cnt_o, 16'd3);
`endif
        send(16'h4000);
        check("sat_pulse_once", 16'(hop_sat_o), 16'd0);
        idle_cycles(3);

        // body in IDLE is dropped
        send(16'h0123);
        check("drop_err", 16'(proto_err_o), 16'd1);
        check("drop_valid", 16'(valid_o), 16'd0);
        check("drop_ready", 16'(ready_o), 16'd1);
        idle_cycles(1);
        check("drop_err_once", 16'(proto_err_o), 16'd0);

        // stall: two accepted, then full
        ready_i = 1'b0;
        send(16'h8A55);
        send(16'h0123);
        check("stall_ready", 16'(ready_o), 16'd0);
        data_i  = 16'h0456;
        valid_i = 1'b1;
        idle_cycles(3);
        check("stall_ready_held", 16'(ready_o), 16'd0);
        check("stall_data_held", data_o, 16'h9255);
        ready_i = 1'b1;
        send(16'h0456);
        send(16'h4777);
        idle_cycles(4);
        check("stall_drained", 16'(exp_q.size()), 16'd0);

        // reset mid-packet with both entries full
        ready_i = 1'b0;
        send(16'h8A55);
        send(16'h0123);
        rst_i = 1'b1;
        idle_cycles(1);
        rst_i = 1'b0;
        check("mid_rst_valid", 16'(valid_o), 16'd0);
        check("mid_rst_ready", 16'(ready_o), 16'd1);
        check("mid_rst_in_pkt", 16'(in_pkt_o), 16'd0);
        ready_i = 1'b1;
        send(16'h0123);
        check("mid_rst_drop_err", 16'(proto_err_o), 16'd1);
        check("mid_rst_drop_valid", 16'(valid_o), 16'd0);

        // random traffic with random back-pressure
        repeat (400) begin
            if (!valid_i || acc_flag) begin
                t = 2'($urandom_range(0, 3));
                h = 3'($urandom_range(0, 7));
                data_i  = {t, h, 11'($urandom_range(0, 2047))};
                valid_i = ($urandom_range(0, 3) != 0);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        idle_cycles(5);
        check("final_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
